lcd_bus_arbiter: RTL and testbench

- Shares one HD44780-style 1602 LCD parallel bus (8-bit mode) between two independent writers, e.g. a static-text painter and a live-value updater.
- Round-robin arbitration on a per-write basis.
- Sequences each granted write as setup -> EN pulse -> hold -> settle wait; clear/home commands get the long settle time.
- Sits between the requesting FSMs and the LCD pins, all on the 1 kHz tick clock.

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_rr_arbiter.sv | 59 +++++
 rtl/lcd_bus_arbiter.sv | 112 +++++++++++
 tb/tb_lcd_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the 1602 LCD bus arbiter: FSM state encoding,
// HD44780 command bytes, default tick counts and the captured-write record.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_ACK   = 3'd5
  } lcd_state_e;

  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] HOME       = 8'h02;
  localparam logic [7:0] HOME_ALT   = 8'h03;  // low bit is don't-care for return-home
  localparam logic [7:0] ENTRY_INC  = 8'h06;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] FUNC_8B2L  = 8'h38;
  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;

  localparam int DEF_EN_HIGH_TICKS   = 1;
  localparam int DEF_FAST_WAIT_TICKS = 1;
  localparam int DEF_SLOW_WAIT_TICKS = 2;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_wr_t;

  // Clear and return-home are the only commands needing the long settle time.
  function automatic logic is_slow_cmd(input lcd_wr_t wr);
    return !wr.rs && ((wr.data == CLEAR) || (wr.data == HOME) || (wr.data == HOME_ALT));
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin grant for the LCD bus. The pointer only moves on a
// completed write. Optional macro LCD_ARB_LOCK_EN adds per-requester locks
// that pin the bus to the last owner while its lock is held.
module lcd_rr_arbiter (
  input  logic       clock_1khz,
  input  logic       rst,
  input  logic [1:0] i_req,
`ifdef LCD_ARB_LOCK_EN
  input  logic [1:0] i_lock,
`endif
  input  logic       i_ack,
  input  logic       i_ack_idx,
  output logic       o_gnt_vld,
  output logic       o_gnt_idx
);

  logic r_prio;  // requester favoured when both are pending

`ifdef LCD_ARB_LOCK_EN
  logic r_hold;      // last owner finished with its lock still high
  logic r_hold_idx;
`endif

  // Grant selection; only consumed by the top while it sits in IDLE.
  always_comb begin
    o_gnt_vld = |i_req;
    o_gnt_idx = (i_req == 2'b11) ? r_prio : i_req[1];
`ifdef LCD_ARB_LOCK_EN
    if (r_hold && i_lock[r_hold_idx]) begin
      o_gnt_vld = i_req[r_hold_idx];
      o_gnt_idx = r_hold_idx;
    end
`endif
  end

  // Pointer update on each completed write.
  always_ff @(posedge clock_1khz or posedge rst) begin
    if (rst) begin
      r_prio     <= 1'b0;
`ifdef LCD_ARB_LOCK_EN
      r_hold     <= 1'b0;
      r_hold_idx <= 1'b0;
`endif
    end else if (i_ack) begin
`ifdef LCD_ARB_LOCK_EN
      if (i_lock[i_ack_idx]) begin
        r_hold     <= 1'b1;
        r_hold_idx <= i_ack_idx;
      end else begin
        r_hold     <= 1'b0;
        r_prio     <= ~i_ack_idx;
      end
`else
      r_prio <= ~i_ack_idx;
`endif
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one HD44780 8-bit parallel bus between two writers. Each granted
// write runs SETUP -> PULSE -> HOLD -> WAIT -> ACK on the 1 kHz tick.
// Optional macro LCD_ARB_LOCK_EN adds lock0/lock1 inputs that keep the bus
// with the current owner across a multi-write sequence.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int EN_HIGH_TICKS   = DEF_EN_HIGH_TICKS,
  parameter int FAST_WAIT_TICKS = DEF_FAST_WAIT_TICKS,
  parameter int SLOW_WAIT_TICKS = DEF_SLOW_WAIT_TICKS
) (
  input  logic       clock_1khz,
  input  logic       rst,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
`ifdef LCD_ARB_LOCK_EN
  input  logic       lock0,
  input  logic       lock1,
`endif
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       owner
);

  lcd_state_e r_state, w_state_nxt;
  lcd_wr_t    r_wr;        // captured write; also drives the bus pins
  logic       r_owner;
  logic [3:0] r_cnt;       // shared down-counter for PULSE and WAIT
  logic [3:0] w_wait_ticks;
  logic       w_gnt_vld, w_gnt_idx;
  logic       w_grant;

  assign w_wait_ticks = is_slow_cmd(r_wr) ? 4'(SLOW_WAIT_TICKS) : 4'(FAST_WAIT_TICKS);
  assign w_grant      = (r_state == ST_IDLE) && w_gnt_vld;

  lcd_rr_arbiter u_arb (
    .clock_1khz (clock_1khz),
    .rst        (rst),
    .i_req      ({req1, req0}),
`ifdef LCD_ARB_LOCK_EN
    .i_lock     ({lock1, lock0}),
`endif
    .i_ack      (r_state == ST_ACK),
    .i_ack_idx  (r_owner),
    .o_gnt_vld  (w_gnt_vld),
    .o_gnt_idx  (w_gnt_idx)
  );

  // State register; reset drops the strobe immediately and abandons the write.
  always_ff @(posedge clock_1khz or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state sequencing of one bus write.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_gnt_vld) w_state_nxt = ST_SETUP;
      ST_SETUP: w_state_nxt = ST_PULSE;
      ST_PULSE: if (r_cnt == 4'd0) w_state_nxt = ST_HOLD;
      ST_HOLD:  w_state_nxt = (w_wait_ticks == 4'd0) ? ST_ACK : ST_WAIT;
      ST_WAIT:  if (r_cnt == 4'd0) w_state_nxt = ST_ACK;
      ST_ACK:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the winner's byte at grant and run the phase counter.
  always_ff @(posedge clock_1khz or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_owner <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      if (w_grant) begin
        r_owner <= w_gnt_idx;
        r_wr    <= w_gnt_idx ? lcd_wr_t'{rs: rs1, data: data1}
                             : lcd_wr_t'{rs: rs0, data: data0};
      end
      case (r_state)
        ST_SETUP: r_cnt <= 4'(EN_HIGH_TICKS - 1);
        ST_HOLD:  r_cnt <= w_wait_ticks - 4'd1;
        ST_PULSE,
        ST_WAIT:  if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        default:  r_cnt <= r_cnt;
      endcase
    end
  end

  // Pin and handshake outputs decoded from state; bus holds last byte when idle.
  always_comb begin
    lcd_en   = (r_state == ST_PULSE);
    lcd_rs   = r_wr.rs;
    lcd_data = r_wr.data;
    lcd_rw   = 1'b0;
    busy     = (r_state != ST_IDLE);
    owner    = r_owner;
    ack0     = (r_state == ST_ACK) && !r_owner;
    ack1     = (r_state == ST_ACK) &&  r_owner;
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Randomised and directed bench for lcd_bus_arbiter against a timeline model:
// each granted write lasts 3+EN+W cycles with the strobe in phases 2..1+EN.
module tb_lcd_bus_arbiter;

  localparam int EN = 1;
  localparam int FW = 1;
  localparam int SW = 2;

  logic       clock_1khz = 1'b0;
  logic       rst;
  logic       req0, rs0, req1, rs1;
  logic [7:0] data0, data1;
  logic       lock0, lock1;
  logic       ack0, ack1, lcd_en, lcd_rs, lcd_rw, busy, owner;
  logic [7:0] lcd_data;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_bus_arbiter #(
    .EN_HIGH_TICKS  (EN),
    .FAST_WAIT_TICKS(FW),
    .SLOW_WAIT_TICKS(SW)
  ) dut (
    .clock_1khz(clock_1khz),
    .rst       (rst),
    .req0      (req0),
    .rs0       (rs0),
    .data0     (data0),
`ifdef LCD_ARB_LOCK_EN
    .lock0     (lock0),
    .lock1     (lock1),
`endif
    .ack0      (ack0),
    .req1      (req1),
    .rs1       (rs1),
    .data1     (data1),
    .ack1      (ack1),
    .lcd_en    (lcd_en),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_data  (lcd_data),
    .busy      (busy),
    .owner     (owner)
  );

  always #5 clock_1khz = ~clock_1khz;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_act, m_own, m_last, m_hold, m_hidx, m_rs;
  int         m_ph, m_len;
  logic [7:0] m_data;

  function automatic int wticks(input bit rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? SW : FW;
  endfunction

  task automatic m_reset();
    m_act = 0; m_own = 0; m_rs = 0; m_data = 8'h00;
    m_last = 1; m_hold = 0; m_hidx = 0; m_ph = 0; m_len = 0;
  endtask

  task automatic m_edge();
    bit g, gi;
    if (m_act) begin
      if (m_ph == m_len) begin
        m_act = 0;
        if (m_own ? lock1 : lock0) begin m_hold = 1; m_hidx = m_own; end
        else begin m_hold = 0; m_last = m_own; end
      end else m_ph++;
    end else begin
      g  = req0 || req1;
      gi = (req0 && req1) ? ~m_last : req1;
      if (m_hold && (m_hidx ? lock1 : lock0)) begin
        g  = m_hidx ? req1 : req0;
        gi = m_hidx;
      end
      if (g) begin
        m_act = 1; m_ph = 1; m_own = gi;
        m_rs   = gi ? rs1 : rs0;
        m_data = gi ? data1 : data0;
        m_len  = 3 + EN + wticks(m_rs, m_data);
      end
    end
  endtask

  function automatic bit m_ack(input bit idx);
    return m_act && (m_ph == m_len) && (m_own == idx);
  endfunction

  task automatic check_outputs();
    chk("busy",     busy,     m_act);
    chk("lcd_en",   lcd_en,   m_act && m_ph >= 2 && m_ph <= 1 + EN);
    chk("ack0",     ack0,     m_ack(0));
    chk("ack1",     ack1,     m_ack(1));
    chk("owner",    owner,    m_own);
    chk("lcd_rs",   lcd_rs,   m_rs);
    chk("lcd_data", lcd_data, m_data);
    chk("lcd_rw",   lcd_rw,   0);
  endtask

  task automatic cyc();
    @(posedge clock_1khz);
    if (rst) m_reset(); else m_edge();
    #1;
    check_outputs();
  endtask

  // One write from a single requester, measured on the DUT pins.
  task automatic do_write(input bit idx, input bit rs, input logic [7:0] d, input bit change,
                          output int lat, output int en_n, output logic [7:0] en_d);
    int t, g;
    bit done;
    t = 0; g = -1; done = 0; lat = -1; en_n = 0; en_d = 8'hxx;
    if (idx) begin req1 = 1; rs1 = rs; data1 = d; end
    else     begin req0 = 1; rs0 = rs; data0 = d; end
    while (!done && t < 30) begin
      cyc(); t++;
      if (busy && g < 0) begin
        g = t - 1;
        if (change) begin if (idx) data1 = d + 8'd1; else data0 = d + 8'd1; end
      end
      if (lcd_en) begin en_n++; en_d = lcd_data; end
      if (idx ? ack1 : ack0) begin done = 1; lat = t - g; end
    end
    chk("write_done", done, 1);
    if (idx) req1 = 0; else req0 = 0;
  endtask

  function automatic logic [7:0] rnd_byte();
    case ($urandom_range(0, 5))
      0: return 8'h01;
      1: return 8'h02;
      2: return 8'h03;
      3: return 8'h80;
      4: return 8'hC0;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int lat, en_n, c0, c1, t, n, first1;
    logic [7:0] en_d;
    int seq[$];

    rst = 1; req0 = 0; rs0 = 0; data0 = 0; req1 = 0; rs1 = 0; data1 = 0;
    lock0 = 0; lock1 = 0;
    m_reset();
    cyc(); cyc();
    rst = 0;
    cyc();

    // single data write from requester 0
    do_write(0, 1, 8'h48, 0, lat, en_n, en_d);
    chk("w48_lat", lat, 5);
    chk("w48_en_cycles", en_n, 1);
    chk("w48_en_data", en_d, 8'h48);
    cyc();

    // data changed after grant is ignored
    do_write(0, 1, 8'h41, 1, lat, en_n, en_d);
    chk("capture_data", en_d, 8'h41);
    cyc();

    // slow vs fast settle
    do_write(1, 0, 8'h01, 0, lat, en_n, en_d);
    chk("clear_lat", lat, 6);
    cyc();
    do_write(1, 0, 8'h80, 0, lat, en_n, en_d);
    chk("addr_lat", lat, 5);
    cyc();

    // both pending: strict alternation, starting with 0 since 1 was served last
    c0 = 0; c1 = 0; t = 0;
    req0 = 1; rs0 = 1; data0 = 8'h30; req1 = 1; rs1 = 1; data1 = 8'h60;
    while ((c0 < 4 || c1 < 4) && t < 100) begin
      cyc(); t++;
      if (ack0) begin seq.push_back(0); c0++; if (c0 == 4) req0 = 0; else data0++; end
      if (ack1) begin seq.push_back(1); c1++; if (c1 == 4) req1 = 0; else data1++; end
    end
    chk("alt_count", seq.size(), 8);
    foreach (seq[k]) chk($sformatf("alt_owner%0d", k), seq[k], k % 2);
    cyc();

    // reset during the strobe
    req0 = 1; rs0 = 1; data0 = 8'h55; t = 0;
    while (!lcd_en && t < 10) begin cyc(); t++; end
    chk("pulse_reached", lcd_en, 1);
    rst = 1; m_reset();
    #1;
    chk("rst_en_drop", lcd_en, 0);
    chk("rst_busy_drop", busy, 0);
    check_outputs();
    cyc();
    rst = 0;
    do_write(0, 1, 8'h55, 0, lat, en_n, en_d);
    chk("regrant_lat", lat, 5);
    chk("regrant_en_data", en_d, 8'h55);
    cyc();

    // randomised traffic
    for (int cy = 0; cy < 1500; cy++) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        bit r;
        r = i ? req1 : req0;
        if (m_ack(i[0])) begin
          if ($urandom_range(0, 1) == 1) begin
            if (i) begin rs1 = 1'($urandom); data1 = rnd_byte(); end
            else   begin rs0 = 1'($urandom); data0 = rnd_byte(); end
          end else begin
            if (i) req1 = 0; else req0 = 0;
          end
        end else if (m_act && m_own == i[0]) begin
          if ($urandom_range(0, 3) == 0) begin if (i) data1 = 8'($urandom); else data0 = 8'($urandom); end
          if (r && $urandom_range(0, 7) == 0) begin if (i) req1 = 0; else req0 = 0; end
        end else if (!r && $urandom_range(0, 2) == 0) begin
          if (i) begin req1 = 1; rs1 = 1'($urandom); data1 = rnd_byte(); end
          else   begin req0 = 1; rs0 = 1'($urandom); data0 = rnd_byte(); end
        end
      end
    end
    req0 = 0; req1 = 0;
    repeat (10) cyc();

`ifdef LCD_ARB_LOCK_EN
    // locked line write: address + 16 characters uninterrupted
    lock0 = 1; req0 = 1; rs0 = 0; data0 = 8'hC0;
    cyc();
    req1 = 1; rs1 = 1; data1 = 8'h5A;
    n = 0; first1 = -1; t = 0;
    while (first1 < 0 && t < 200) begin
      cyc(); t++;
      if (ack0) begin
        n++;
        if (n == 17) begin req0 = 0; lock0 = 0; end
        else begin rs0 = 1; data0 = 8'h41 + 8'(n); end
      end
      if (ack1) begin first1 = n; req1 = 0; end
    end
    chk("lock_run_len", first1, 17);
    repeat (5) cyc();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
